// File: rtl/sound_ch1_ioregs.sv
// Pulse channel 1 register file (NR10-NR14) and master control (NR52), with length counter and trigger.
// Define SOUND_CH1_READBACK_MASK_EN to make unused and write-only bits read back as 1.
module sound_ch1_ioregs #(
  parameter logic [15:0] BASE_ADDR = 16'hFF10,
  parameter logic [15:0] CTRL_ADDR = 16'hFF26
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic        I_LEN_TICK,
  output logic [7:0]  O_NR10,
  output logic [7:0]  O_NR11,
  output logic [7:0]  O_NR12,
  output logic [7:0]  O_NR13,
  output logic [7:0]  O_NR14,
  output logic        O_TRIGGER,
  output logic        O_CH1_ON,
  output logic        O_POWER
);

`ifdef SOUND_CH1_READBACK_MASK_EN
  localparam logic [7:0] MASK_NR10 = 8'h80;
  localparam logic [7:0] MASK_NR11 = 8'h3F;
  localparam logic [7:0] MASK_NR12 = 8'h00;
  localparam logic [7:0] MASK_NR13 = 8'hFF;
  localparam logic [7:0] MASK_NR14 = 8'hBF;
  localparam logic [7:0] MASK_NR52 = 8'h70;
`else
  localparam logic [7:0] MASK_NR10 = 8'h00;
  localparam logic [7:0] MASK_NR11 = 8'h00;
  localparam logic [7:0] MASK_NR12 = 8'h00;
  localparam logic [7:0] MASK_NR13 = 8'h00;
  localparam logic [7:0] MASK_NR14 = 8'h00;
  localparam logic [7:0] MASK_NR52 = 8'h00;
`endif

  localparam logic [6:0] LEN_FULL = 7'd64;

  logic [7:0] nr10_q, nr10_d;
  logic [7:0] nr11_q, nr11_d;
  logic [7:0] nr12_q, nr12_d;
  logic [7:0] nr13_q, nr13_d;
  logic [7:0] nr14_q, nr14_d;
  logic [6:0] len_q, len_d;
  logic       ch1_on_q, ch1_on_d;
  logic       power_q, power_d;
  logic       trigger_q, trigger_d;

  logic [4:0] sel_nr;
  logic       sel_ctrl;
  logic       hit;
  logic       wr_nr;
  logic       wr_ctrl;
  logic       rd_drive;
  logic [7:0] rd_data;
  logic [7:0] wr_data;
  logic       dac_on;
  logic       tick_dec;

  assign wr_data = IO_IOREG_DATA;
  assign dac_on  = (nr12_q[7:3] != 5'd0);

  always_comb begin
    sel_nr[0] = (I_IOREG_ADDR == BASE_ADDR);
    sel_nr[1] = (I_IOREG_ADDR == BASE_ADDR + 16'd1);
    sel_nr[2] = (I_IOREG_ADDR == BASE_ADDR + 16'd2);
    sel_nr[3] = (I_IOREG_ADDR == BASE_ADDR + 16'd3);
    sel_nr[4] = (I_IOREG_ADDR == BASE_ADDR + 16'd4);
    sel_ctrl  = (I_IOREG_ADDR == CTRL_ADDR);
    hit       = (sel_nr != 5'd0) || sel_ctrl;
    // Channel registers are frozen while the master enable is off; NR52 always accepts writes.
    wr_nr     = !I_IOREG_WE_L && power_q;
    wr_ctrl   = !I_IOREG_WE_L && sel_ctrl;
    rd_drive  = !I_IOREG_RE_L && I_IOREG_WE_L && hit;
  end

  always_comb begin
    if (sel_nr[0]) begin
      rd_data = nr10_q | MASK_NR10;
    end else if (sel_nr[1]) begin
      rd_data = nr11_q | MASK_NR11;
    end else if (sel_nr[2]) begin
      rd_data = nr12_q | MASK_NR12;
    end else if (sel_nr[3]) begin
      rd_data = nr13_q | MASK_NR13;
    end else if (sel_nr[4]) begin
      rd_data = nr14_q | MASK_NR14;
    end else if (sel_ctrl) begin
      rd_data = {power_q, 6'b000000, ch1_on_q} | MASK_NR52;
    end else begin
      rd_data = 8'h00;
    end
  end

  assign IO_IOREG_DATA = rd_drive ? rd_data : 8'hzz;

  always_comb begin
    nr10_d    = nr10_q;
    nr11_d    = nr11_q;
    nr12_d    = nr12_q;
    nr13_d    = nr13_q;
    nr14_d    = nr14_q;
    len_d     = len_q;
    ch1_on_d  = ch1_on_q;
    power_d   = power_q;
    trigger_d = 1'b0;
    tick_dec  = I_LEN_TICK && nr14_q[6] && (len_q != 7'd0);

    if (tick_dec) begin
      len_d = len_q - 7'd1;
      if (len_q == 7'd1) begin
        ch1_on_d = 1'b0;
      end else begin
        ch1_on_d = ch1_on_q;
      end
    end else begin
      len_d = len_q;
    end

    // Register writes are applied after the tick so that a load, trigger or clear overrides it.
    if (wr_nr && sel_nr[0]) begin
      nr10_d = wr_data;
    end else if (wr_nr && sel_nr[1]) begin
      nr11_d = wr_data;
      len_d  = LEN_FULL - {1'b0, wr_data[5:0]};
    end else if (wr_nr && sel_nr[2]) begin
      nr12_d = wr_data;
      if (wr_data[7:3] == 5'd0) begin
        ch1_on_d = 1'b0;
      end else begin
        ch1_on_d = ch1_on_d;
      end
    end else if (wr_nr && sel_nr[3]) begin
      nr13_d = wr_data;
    end else if (wr_nr && sel_nr[4]) begin
      nr14_d = wr_data;
      if (wr_data[7]) begin
        trigger_d = 1'b1;
        ch1_on_d  = dac_on;
        len_d     = (len_q == 7'd0) ? LEN_FULL : len_q;
      end else begin
        trigger_d = 1'b0;
      end
    end else if (wr_ctrl) begin
      power_d = wr_data[7];
      if (!wr_data[7]) begin
        nr10_d   = 8'h00;
        nr11_d   = 8'h00;
        nr12_d   = 8'h00;
        nr13_d   = 8'h00;
        nr14_d   = 8'h00;
        len_d    = 7'd0;
        ch1_on_d = 1'b0;
      end else begin
        ch1_on_d = ch1_on_d;
      end
    end else begin
      power_d = power_q;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      nr10_q    <= 8'h00;
      nr11_q    <= 8'h00;
      nr12_q    <= 8'h00;
      nr13_q    <= 8'h00;
      nr14_q    <= 8'h00;
      len_q     <= 7'd0;
      ch1_on_q  <= 1'b0;
      power_q   <= 1'b1;
      trigger_q <= 1'b0;
    end else begin
      nr10_q    <= nr10_d;
      nr11_q    <= nr11_d;
      nr12_q    <= nr12_d;
      nr13_q    <= nr13_d;
      nr14_q    <= nr14_d;
      len_q     <= len_d;
      ch1_on_q  <= ch1_on_d;
      power_q   <= power_d;
      trigger_q <= trigger_d;
    end
  end

  assign O_NR10    = nr10_q;
  assign O_NR11    = nr11_q;
  assign O_NR12    = nr12_q;
  assign O_NR13    = nr13_q;
  assign O_NR14    = nr14_q;
  assign O_TRIGGER = trigger_q;
  assign O_CH1_ON  = ch1_on_q;
  assign O_POWER   = power_q;

endmodule

// File: tb/tb_sound_ch1_ioregs.sv
// Directed bench for sound_ch1_ioregs: register writes, bus reads, trigger, length counter, power control.
module tb_sound_ch1_ioregs;
  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we_l;
  logic        re_l;
  logic        len_tick;
  logic        tb_en;
  logic [7:0]  tb_dat;
  wire  [7:0]  io_data;
  logic [7:0]  nr10, nr11, nr12, nr13, nr14;
  logic        trig, ch1_on, power;

  int n_checks;
  int n_fails;

  assign io_data = tb_en ? tb_dat : 8'hzz;

  sound_ch1_ioregs dut (
    .I_CLK(clk), .I_RESET(rst), .I_IOREG_ADDR(addr), .IO_IOREG_DATA(io_data),
    .I_IOREG_WE_L(we_l), .I_IOREG_RE_L(re_l), .I_LEN_TICK(len_tick),
    .O_NR10(nr10), .O_NR11(nr11), .O_NR12(nr12), .O_NR13(nr13), .O_NR14(nr14),
    .O_TRIGGER(trig), .O_CH1_ON(ch1_on), .O_POWER(power)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic tick);
    @(negedge clk);
    addr = a; tb_dat = d; tb_en = 1'b1; we_l = 1'b0; len_tick = tick;
    @(negedge clk);
    we_l = 1'b1; tb_en = 1'b0; len_tick = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; re_l = 1'b0;
    #2;
    d = io_data;
    #1;
    re_l = 1'b1; addr = 16'h0000;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      len_tick = 1'b1;
      @(negedge clk);
      len_tick = 1'b0;
    end
  endtask

  logic [15:0] rd_addr [6];
  logic [7:0]  rd_exp  [6];
  logic [7:0]  rd_val;

  initial begin
    n_checks = 0; n_fails = 0;
    rst = 1'b1; addr = 16'h0000; we_l = 1'b1; re_l = 1'b1; len_tick = 1'b0;
    tb_en = 1'b0; tb_dat = 8'h00;
    rd_addr[0] = 16'hFF10; rd_addr[1] = 16'hFF11; rd_addr[2] = 16'hFF12;
    rd_addr[3] = 16'hFF13; rd_addr[4] = 16'hFF14; rd_addr[5] = 16'hFF26;
`ifdef SOUND_CH1_READBACK_MASK_EN
    rd_exp[0] = 8'h80; rd_exp[1] = 8'h3F; rd_exp[2] = 8'h00;
    rd_exp[3] = 8'hFF; rd_exp[4] = 8'hBF; rd_exp[5] = 8'hF0;
`else
    rd_exp[0] = 8'h00; rd_exp[1] = 8'h00; rd_exp[2] = 8'h00;
    rd_exp[3] = 8'h00; rd_exp[4] = 8'h00; rd_exp[5] = 8'h80;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and reset-value readback
    check_eq("rst_nr10", nr10, 8'h00);
    check_eq("rst_nr14", nr14, 8'h00);
    check_eq("rst_trig", {7'd0, trig}, 8'h00);
    check_eq("rst_on", {7'd0, ch1_on}, 8'h00);
    check_eq("rst_power", {7'd0, power}, 8'h01);
    for (int i = 0; i < 6; i++) begin
      bus_read(rd_addr[i], rd_val);
      check_eq($sformatf("rst_read_%h", rd_addr[i]), rd_val, rd_exp[i]);
    end

    // Bus released: an external driver must win when RE_L is high or the address misses
    @(negedge clk);
    addr = 16'hFF26; tb_en = 1'b1; tb_dat = 8'hA5; #2;
    check_eq("hiz_re_high", io_data, 8'hA5);
    addr = 16'hFF20; re_l = 1'b0; tb_dat = 8'h5A; #2;
    check_eq("hiz_miss", io_data, 8'h5A);
    re_l = 1'b1; tb_en = 1'b0; addr = 16'h0000;

    // Write sequence with trigger
    bus_write(16'hFF10, 8'h11, 1'b0);
    bus_write(16'hFF11, 8'h80, 1'b0);
    bus_write(16'hFF12, 8'hF7, 1'b0);
    bus_write(16'hFF13, 8'hD6, 1'b0);
    check_eq("pre_trig", {7'd0, trig}, 8'h00);
    bus_write(16'hFF14, 8'hC6, 1'b0);
    check_eq("trig_pulse", {7'd0, trig}, 8'h01);
    check_eq("seq_on", {7'd0, ch1_on}, 8'h01);
    check_eq("seq_nr10", nr10, 8'h11);
    check_eq("seq_nr11", nr11, 8'h80);
    check_eq("seq_nr12", nr12, 8'hF7);
    check_eq("seq_nr13", nr13, 8'hD6);
    check_eq("seq_nr14", nr14, 8'hC6);
    @(negedge clk);
    check_eq("trig_one_cycle", {7'd0, trig}, 8'h00);
    bus_read(16'hFF14, rd_val);
`ifdef SOUND_CH1_READBACK_MASK_EN
    check_eq("read_nr14", rd_val, 8'hFF);
`else
    check_eq("read_nr14", rd_val, 8'hC6);
`endif
    // Counter was loaded with 64: on through 63 ticks, off at the 64th
    tick_n(63);
    check_eq("len64_63t", {7'd0, ch1_on}, 8'h01);
    tick_n(1);
    check_eq("len64_64t", {7'd0, ch1_on}, 8'h00);

    // Short length: NR11=3E gives a count of 2
    bus_write(16'hFF11, 8'h3E, 1'b0);
    bus_write(16'hFF14, 8'hC0, 1'b0);
    check_eq("len2_trig", {7'd0, trig}, 8'h01);
    check_eq("len2_on", {7'd0, ch1_on}, 8'h01);
    tick_n(1);
    check_eq("len2_1t", {7'd0, ch1_on}, 8'h01);
    tick_n(1);
    check_eq("len2_2t", {7'd0, ch1_on}, 8'h00);
    tick_n(1);
    check_eq("len2_3t", {7'd0, ch1_on}, 8'h00);

    // DAC off behaviour
    bus_write(16'hFF14, 8'h80, 1'b0);
    check_eq("dac_retrig_on", {7'd0, ch1_on}, 8'h01);
    bus_write(16'hFF12, 8'h07, 1'b0);
    check_eq("dac_off_clear", {7'd0, ch1_on}, 8'h00);
    bus_write(16'hFF14, 8'h80, 1'b0);
    check_eq("dac_off_trig", {7'd0, trig}, 8'h01);
    check_eq("dac_off_on", {7'd0, ch1_on}, 8'h00);
    bus_write(16'hFF12, 8'hF0, 1'b0);
    check_eq("dac_on_nochg", {7'd0, ch1_on}, 8'h00);

    // Power off and on
    bus_write(16'hFF14, 8'h80, 1'b0);
    bus_write(16'hFF26, 8'h00, 1'b0);
    check_eq("poff_power", {7'd0, power}, 8'h00);
    check_eq("poff_on", {7'd0, ch1_on}, 8'h00);
    check_eq("poff_nr10", nr10, 8'h00);
    check_eq("poff_nr11", nr11, 8'h00);
    check_eq("poff_nr12", nr12, 8'h00);
    check_eq("poff_nr13", nr13, 8'h00);
    check_eq("poff_nr14", nr14, 8'h00);
    bus_write(16'hFF12, 8'hF0, 1'b0);
    check_eq("poff_wr_ignored", nr12, 8'h00);
    bus_read(16'hFF26, rd_val);
`ifdef SOUND_CH1_READBACK_MASK_EN
    check_eq("poff_read52", rd_val, 8'h70);
`else
    check_eq("poff_read52", rd_val, 8'h00);
`endif
    bus_write(16'hFF26, 8'h80, 1'b0);
    check_eq("pon_power", {7'd0, power}, 8'h01);
    bus_write(16'hFF12, 8'hF0, 1'b0);
    check_eq("pon_nr12", nr12, 8'hF0);

    // Trigger and tick together with counter 0: reload to 64, no decrement
    bus_write(16'hFF14, 8'hC0, 1'b1);
    check_eq("trtick_trig", {7'd0, trig}, 8'h01);
    check_eq("trtick_on", {7'd0, ch1_on}, 8'h01);
    tick_n(63);
    check_eq("trtick_63t", {7'd0, ch1_on}, 8'h01);
    tick_n(1);
    check_eq("trtick_64t", {7'd0, ch1_on}, 8'h00);

    // NR11 load and tick together: load wins (count 1, drops on next tick)
    bus_write(16'hFF14, 8'hC0, 1'b0);
    bus_write(16'hFF11, 8'h3F, 1'b1);
    check_eq("ldtick_on", {7'd0, ch1_on}, 8'h01);
    tick_n(1);
    check_eq("ldtick_1t", {7'd0, ch1_on}, 8'h00);

    // Reset during a trigger write suppresses the pulse
    @(negedge clk);
    addr = 16'hFF14; tb_dat = 8'h80; tb_en = 1'b1; we_l = 1'b0; rst = 1'b1;
    @(negedge clk);
    we_l = 1'b1; tb_en = 1'b0; rst = 1'b0; addr = 16'h0000;
    check_eq("mrst_trig", {7'd0, trig}, 8'h00);
    check_eq("mrst_nr12", nr12, 8'h00);
    check_eq("mrst_nr14", nr14, 8'h00);
    check_eq("mrst_power", {7'd0, power}, 8'h01);
    @(negedge clk);
    check_eq("mrst_trig_late", {7'd0, trig}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
